// File: rtl/tc_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters.
// Define TC_SRAM_ARB_WRITE_ACK_EN to return a zero-data rvalid for writes.
module tc_sram_arbiter #(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned AddrWidth =
      (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth   =
      (DataWidth + ByteWidth - 1) / ByteWidth,
   parameter int unsigned IdxWidth  =
      (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumReq-1:0]                   req_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [NumReq-1:0][DataWidth-1:0]    rdata_o,
   output logic                                sram_req_o,
   output logic                                sram_we_o,
   output logic [AddrWidth-1:0]                sram_addr_o,
   output logic [DataWidth-1:0]                sram_wdata_o,
   output logic [BeWidth-1:0]                  sram_be_o,
   input  logic [DataWidth-1:0]                sram_rdata_i
);

   logic [IdxWidth-1:0] rr_q, rr_d, sel;
   logic                found;
   logic                push;
   int unsigned         cand;

   logic [Latency-1:0]               vld_q;
   logic [Latency-1:0][IdxWidth-1:0] idx_q;
   logic [DataWidth-1:0]             resp_data;

   // Search starts at the pointer and wraps; first requester found wins.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      gnt_o = '0;
      cand  = 0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = 32'(rr_q) + i;
         if (cand >= NumReq) cand = cand - NumReq;
         if (!found && req_i[IdxWidth'(cand)]) begin
            found = 1'b1;
            sel   = IdxWidth'(cand);
         end
      end
      if (found) gnt_o[sel] = 1'b1;
   end

   always_comb begin
      sram_req_o   = found;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      if (found) begin
         sram_we_o    = we_i[sel];
         sram_addr_o  = addr_i[sel];
         sram_wdata_o = wdata_i[sel];
         sram_be_o    = be_i[sel];
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (found) begin
         if (sel == IdxWidth'(NumReq - 1)) rr_d = '0;
         else rr_d = sel + IdxWidth'(1);
      end
   end

`ifdef TC_SRAM_ARB_WRITE_ACK_EN
   logic [Latency-1:0] wr_q;

   assign push      = found;
   assign resp_data = wr_q[Latency-1] ? '0 : sram_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
      end else begin
         wr_q[0] <= we_i[sel];
         for (int unsigned i = 1; i < Latency; i++) begin
            wr_q[i] <= wr_q[i-1];
         end
      end
   end
`else
   assign push      = found & ~we_i[sel];
   assign resp_data = sram_rdata_i;
`endif

   // Grant index travels alongside the SRAM read latency.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q  <= '0;
         vld_q <= '0;
         idx_q <= '0;
      end else begin
         rr_q     <= rr_d;
         vld_q[0] <= push;
         idx_q[0] <= sel;
         for (int unsigned i = 1; i < Latency; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   always_comb begin
      rvalid_o = '0;
      if (vld_q[Latency-1]) rvalid_o[idx_q[Latency-1]] = 1'b1;
   end

   assign rdata_o = {NumReq{resp_data}};

`ifndef SYNTHESIS
   if (Latency < 1 || NumReq < 1) begin : g_bad_param
      $error("tc_sram_arbiter: Latency and NumReq must be >= 1");
   end

   a_gnt_onehot: assert property (
      @(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

   for (genvar k = 0; k < NumReq; k++) begin : g_hold
      a_req_hold: assert property (
         @(posedge clk_i) disable iff (!rst_ni)
         (req_i[k] && !gnt_o[k]) |=> req_i[k]);
   end
`endif

endmodule
